// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq: sequences register COPY/SWAP transfers over split hi/lo data buses.
module reg_xfer_seq (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [3:0] req_src,
  input  logic [3:0] req_dst,
  input  logic [7:0] db_hi_in,
  input  logic [7:0] db_lo_in,
  output logic [7:0] db_hi_out,
  output logic [7:0] db_lo_out,
  output logic       db_hi_oe,
  output logic       db_lo_oe,
  output logic       ctl_reg_sel_gp,
  output logic       ctl_reg_sel_gp_16,
  output logic       ctl_reg_gp_oe,
  output logic [2:0] reg_sel,
  output logic       ctl_reg_sel_wz,
  output logic       ctl_reg_sel_pc,
  output logic       ctl_reg_sel_ir,
  output logic       ctl_reg_sel_sys_hi,
  output logic       ctl_reg_sel_sys_lo,
  output logic       ctl_reg_sys_oe,
  output logic       ctl_sw_4d,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE} state_t;
  state_t state;
  logic [3:0] src, dst, cur;
  logic op, err_r, rd, wr, act, sys, gp, bad;
  logic [15:0] ha, hb, wd, cap;
  // code[3] marks a 16-bit operand; code 15 is the only invalid one
  assign bad = (&req_src) | (&req_dst) | (req_src[3] ^ req_dst[3]);
  assign rd  = (state == RD_A) || (state == RD_B);
  assign wr  = (state == WR_A) || (state == WR_B);
  assign act = rd | wr;
  assign cur = (state == RD_A || state == WR_A) ? src : dst;
  // 8-bit captures are normalised into the low byte so any lane can receive them
  assign cap = cur[3] ? {db_hi_in, db_lo_in} : {8'h00, cur[0] ? db_lo_in : db_hi_in};
  assign wd  = (state == WR_A) ? hb : ha;
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      op    <= 1'b0;
      err_r <= 1'b0;
      ha    <= '0;
      hb    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          src   <= req_src;
          dst   <= req_dst;
          op    <= req_op;
          err_r <= bad;
          state <= bad ? DONE : RD_A;
        end
        RD_A: begin
          ha    <= cap;
          state <= op ? RD_B : WR_B;
        end
        RD_B: begin
          hb    <= cap;
          state <= WR_A;
        end
        WR_A: state <= WR_B;
        WR_B: state <= DONE;
        default: begin
          err_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  always_comb begin
    sys                = act & cur[3] & cur[2];
    gp                 = act & ~(cur[3] & cur[2]);
    req_ready          = nreset & (state == IDLE);
    ctl_reg_sel_gp     = gp;
    ctl_reg_sel_gp_16  = gp & cur[3];
    ctl_reg_gp_oe      = gp & rd;
    reg_sel            = gp ? (cur[3] ? {cur[1:0], 1'b0} : cur[2:0]) : 3'b000;
    ctl_reg_sel_wz     = sys & (cur[1:0] == 2'd0);
    ctl_reg_sel_pc     = sys & (cur[1:0] == 2'd1);
    ctl_reg_sel_ir     = sys & (cur[1:0] == 2'd2);
    ctl_reg_sel_sys_hi = sys;
    ctl_reg_sel_sys_lo = sys;
    ctl_sw_4d          = sys;
    ctl_reg_sys_oe     = sys & rd;
    db_hi_oe           = wr & (cur[3] | ~cur[0]);
    db_lo_oe           = wr & (cur[3] | cur[0]);
    db_hi_out          = db_hi_oe ? (cur[3] ? wd[15:8] : wd[7:0]) : 8'h00;
    db_lo_out          = db_lo_oe ? wd[7:0] : 8'h00;
    done               = (state == DONE);
    err                = (state == DONE) & err_r;
  end
endmodule

// File: tb/tb_reg_xfer_seq.sv
// tb_reg_xfer_seq: directed COPY/SWAP vectors checked through an event scoreboard.
module tb_reg_xfer_seq;
  logic clk = 1'b0, nreset = 1'b0, req_valid = 1'b0, req_op = 1'b0;
  logic [3:0] req_src = '0, req_dst = '0;
  logic [7:0] db_hi_in, db_lo_in, db_hi_out, db_lo_out;
  logic req_ready, db_hi_oe, db_lo_oe, ctl_reg_sel_gp, ctl_reg_sel_gp_16, ctl_reg_gp_oe;
  logic [2:0] reg_sel;
  logic ctl_reg_sel_wz, ctl_reg_sel_pc, ctl_reg_sel_ir, ctl_reg_sel_sys_hi, ctl_reg_sel_sys_lo;
  logic ctl_reg_sys_oe, ctl_sw_4d, done, err;
  int checks = 0, failures = 0, cyc = 0;

  reg_xfer_seq dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src(req_src), .req_dst(req_dst), .db_hi_in(db_hi_in), .db_lo_in(db_lo_in),
    .db_hi_out(db_hi_out), .db_lo_out(db_lo_out), .db_hi_oe(db_hi_oe), .db_lo_oe(db_lo_oe),
    .ctl_reg_sel_gp(ctl_reg_sel_gp), .ctl_reg_sel_gp_16(ctl_reg_sel_gp_16),
    .ctl_reg_gp_oe(ctl_reg_gp_oe), .reg_sel(reg_sel), .ctl_reg_sel_wz(ctl_reg_sel_wz),
    .ctl_reg_sel_pc(ctl_reg_sel_pc), .ctl_reg_sel_ir(ctl_reg_sel_ir),
    .ctl_reg_sel_sys_hi(ctl_reg_sel_sys_hi), .ctl_reg_sel_sys_lo(ctl_reg_sel_sys_lo),
    .ctl_reg_sys_oe(ctl_reg_sys_oe), .ctl_sw_4d(ctl_sw_4d), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register-file model answering the DUT's reads; 8'hEE marks an unused lane
  logic [7:0] r8 [8];
  logic [15:0] s16 [3];
  logic [15:0] sv;
  always_comb begin
    db_hi_in = 8'hEE;
    db_lo_in = 8'hEE;
    sv = ctl_reg_sel_wz ? s16[0] : ctl_reg_sel_pc ? s16[1] : s16[2];
    if (ctl_reg_gp_oe && ctl_reg_sel_gp_16) begin
      db_hi_in = r8[reg_sel];
      db_lo_in = r8[{reg_sel[2:1], 1'b1}];
    end else if (ctl_reg_gp_oe) begin
      if (reg_sel[0]) db_lo_in = r8[reg_sel];
      else db_hi_in = r8[reg_sel];
    end else if (ctl_reg_sys_oe) begin
      db_hi_in = sv[15:8];
      db_lo_in = sv[7:0];
    end
  end

  logic [28:0] outs;
  assign outs = {db_hi_out, db_lo_out, db_hi_oe, db_lo_oe, ctl_reg_sel_gp, ctl_reg_sel_gp_16,
                 ctl_reg_gp_oe, reg_sel, ctl_reg_sel_wz, ctl_reg_sel_pc, ctl_reg_sel_ir,
                 ctl_reg_sel_sys_hi, ctl_reg_sel_sys_lo, ctl_reg_sys_oe, ctl_sw_4d, done, err};

  // operand code recovered from the select lines; 15 flags an inconsistent combination
  logic sys_any;
  logic [3:0] ac;
  always_comb begin
    sys_any = ctl_reg_sel_wz | ctl_reg_sel_pc | ctl_reg_sel_ir | ctl_reg_sel_sys_hi |
              ctl_reg_sel_sys_lo | ctl_sw_4d;
    ac = 4'hF;
    if (ctl_reg_sel_gp && !sys_any)
      ac = ctl_reg_sel_gp_16 ? (reg_sel[0] ? 4'hF : {2'b10, reg_sel[2:1]}) : {1'b0, reg_sel};
    else if (!ctl_reg_sel_gp && ctl_reg_sel_sys_hi && ctl_reg_sel_sys_lo && ctl_sw_4d &&
             (32'(ctl_reg_sel_wz) + 32'(ctl_reg_sel_pc) + 32'(ctl_reg_sel_ir) == 1))
      ac = ctl_reg_sel_wz ? 4'd12 : ctl_reg_sel_pc ? 4'd13 : 4'd14;
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;
    logic [3:0]  code;
    logic [1:0]  lanes;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        err;
  } ev_t;
  ev_t q[$];

  task automatic push(input logic [1:0] k, input int c, input logic [3:0] code,
                      input logic [1:0] ln, input logic [7:0] h, input logic [7:0] l,
                      input logic e);
    ev_t t;
    t = {c, k, code, ln, h, l, e};
    q.push_back(t);
  endtask
  task automatic rd_ev(input int c, input logic [3:0] code);
    push(2'd0, c, code, 2'b00, 8'h00, 8'h00, 1'b0);
  endtask
  task automatic wr_ev(input int c, input logic [3:0] code, input logic [1:0] ln,
                       input logic [7:0] h, input logic [7:0] l);
    push(2'd1, c, code, ln, h, l, 1'b0);
  endtask
  task automatic dn_ev(input int c, input logic e);
    push(2'd2, c, 4'h0, 2'b00, 8'h00, 8'h00, e);
  endtask

  // monitor: each bus read, bus write or done pulse is matched against the queue head
  always @(negedge clk) begin
    ev_t a, e;
    logic got;
    got = 1'b1;
    a = '0;
    a.cyc = cyc;
    if (ctl_reg_gp_oe || ctl_reg_sys_oe) begin
      a.kind = 2'd0;
      a.code = ac;
    end else if (db_hi_oe || db_lo_oe) begin
      a.kind  = 2'd1;
      a.code  = ac;
      a.lanes = {db_hi_oe, db_lo_oe};
      a.hi    = db_hi_oe ? db_hi_out : 8'h00;
      a.lo    = db_lo_oe ? db_lo_out : 8'h00;
    end else if (done) begin
      a.kind = 2'd2;
      a.err  = err;
      a.code = (outs[28:2] != 0) ? 4'hF : 4'h0;
    end else got = 1'b0;
    if (got) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got=%h required=none", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL event got=%h required=%h", a, e);
        end
      end
    end
    checks++;
    if ((32'(ctl_reg_gp_oe) + 32'(ctl_reg_sys_oe) + 32'(db_hi_oe | db_lo_oe) > 1) ||
        (req_ready && outs != 0) || (err && !done)) begin
      failures++;
      $display("FAIL invariant got ready=%b outs=%h required=exclusive_oe_and_quiet_idle",
               req_ready, outs);
    end
  end

  task automatic issue(input logic op, input logic [3:0] s, input logic [3:0] d, output int n);
    int w;
    w = 0;
    @(negedge clk);
    req_op = op;
    req_src = s;
    req_dst = d;
    req_valid = 1'b1;
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL accept got=ready_low required=ready_high");
    end
    n = cyc + 1;
  endtask

  task automatic go(input bit hold);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain;
    int w;
    w = 0;
    while (q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d_pending required=0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic quiet(input string name, input logic rdy);
    checks++;
    if (outs != 0 || req_ready !== rdy) begin
      failures++;
      $display("FAIL %s got outs=%h ready=%b required outs=0 ready=%b", name, outs, req_ready, rdy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    r8 = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    s16 = '{16'hABCD, 16'h1234, 16'hBEEF};
    repeat (3) @(negedge clk);
    quiet("reset_outs", 1'b0);
    nreset = 1'b1;
    @(negedge clk);
    quiet("reset_release", 1'b1);
    // COPY BC -> DE
    issue(1'b0, 4'd8, 4'd9, n);
    rd_ev(n, 4'd8); wr_ev(n + 1, 4'd9, 2'b11, 8'h80, 8'h40); dn_ev(n + 2, 1'b0);
    go(0); drain();
    // COPY B -> C: byte moves from hi lane to lo lane
    r8[0] = 8'h5A;
    issue(1'b0, 4'd0, 4'd1, n);
    rd_ev(n, 4'd0); wr_ev(n + 1, 4'd1, 2'b01, 8'h00, 8'h5A); dn_ev(n + 2, 1'b0);
    go(0); drain();
    // SWAP PC <-> WZ
    issue(1'b1, 4'd13, 4'd12, n);
    rd_ev(n, 4'd13); rd_ev(n + 1, 4'd12);
    wr_ev(n + 2, 4'd13, 2'b11, 8'hAB, 8'hCD); wr_ev(n + 3, 4'd12, 2'b11, 8'h12, 8'h34);
    dn_ev(n + 4, 1'b0);
    go(0); drain();
    // error cases: width mismatch and invalid code
    issue(1'b0, 4'd6, 4'd10, n); dn_ev(n, 1'b1); go(0); drain();
    issue(1'b0, 4'd15, 4'd0, n); dn_ev(n, 1'b1); go(0); drain();
    issue(1'b1, 4'd0, 4'd8, n); dn_ev(n, 1'b1); go(0); drain();
    issue(1'b0, 4'd12, 4'd15, n); dn_ev(n, 1'b1); go(0); drain();
    // SWAP D <-> E crosses lanes both ways
    r8[2] = 8'h11; r8[3] = 8'h22;
    issue(1'b1, 4'd2, 4'd3, n);
    rd_ev(n, 4'd2); rd_ev(n + 1, 4'd3);
    wr_ev(n + 2, 4'd2, 2'b10, 8'h22, 8'h00); wr_ev(n + 3, 4'd3, 2'b01, 8'h00, 8'h11);
    dn_ev(n + 4, 1'b0);
    go(0); drain();
    // COPY HL -> HL
    r8[4] = 8'h9C; r8[5] = 8'h3E;
    issue(1'b0, 4'd10, 4'd10, n);
    rd_ev(n, 4'd10); wr_ev(n + 1, 4'd10, 2'b11, 8'h9C, 8'h3E); dn_ev(n + 2, 1'b0);
    go(0); drain();
    // SWAP IR <-> AF mixes sys and gp 16-bit operands
    r8[6] = 8'h01; r8[7] = 8'h02;
    issue(1'b1, 4'd14, 4'd11, n);
    rd_ev(n, 4'd14); rd_ev(n + 1, 4'd11);
    wr_ev(n + 2, 4'd14, 2'b11, 8'h01, 8'h02); wr_ev(n + 3, 4'd11, 2'b11, 8'hBE, 8'hEF);
    dn_ev(n + 4, 1'b0);
    go(0); drain();
    // held req_valid: two COPY C -> A back to back, done pulses 4 cycles apart
    r8[1] = 8'h77;
    issue(1'b0, 4'd1, 4'd6, n);
    rd_ev(n, 4'd1); wr_ev(n + 1, 4'd6, 2'b10, 8'h77, 8'h00); dn_ev(n + 2, 1'b0);
    rd_ev(n + 4, 4'd1); wr_ev(n + 5, 4'd6, 2'b10, 8'h77, 8'h00); dn_ev(n + 6, 1'b0);
    go(1);
    issue(1'b0, 4'd1, 4'd6, m);
    go(0); drain();
    // reset during RD_B of a SWAP aborts silently
    issue(1'b1, 4'd13, 4'd12, n);
    rd_ev(n, 4'd13); rd_ev(n + 1, 4'd12);
    go(0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b0;
    req_valid = 1'b1; req_op = 1'b0; req_src = 4'd0; req_dst = 4'd1;
    @(negedge clk);
    quiet("abort_outs", 1'b0);
    checks++;
    if (dut.ha !== 16'h0 || dut.hb !== 16'h0) begin
      failures++;
      $display("FAIL abort_hold got ha=%h hb=%h required=0000", dut.ha, dut.hb);
    end
    @(negedge clk);
    quiet("abort_ignore_valid", 1'b0);
    nreset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    quiet("abort_release", 1'b1);
    drain();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
